alu_result_sel: RTL and testbench
=================================

Name: alu_result_sel

Overview:
- Parametrised, registered successor to the ALU's combinational 8-to-1 result multiplexer.
- Accepts an operation select through a valid/ready handshake, then waits for the selected functional unit's done strobe. Multi-cycle units such as the multiplier and divider are supported.
- Captures that unit's result, computes a zero flag, and holds the result on a valid/ready output until it is consumed.
- Sits between the ALU functional units and the ALU output register/consumer.

Parameters:
- WIDTH, 8, result width in bits.
- NUM_IN, 8, number of functional-unit inputs. Default map: 0 NOT, 1 AND, 2 OR, 3 XOR, 4 ADD, 5 SUB, 6 MULTI, 7 DIV.
- SEL_W, 3, select width; must satisfy 2**SEL_W >= NUM_IN.
- TIMEOUT, 15, maximum WAIT cycles before abort; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op_valid  in  1  operation request.
- op_ready  out  1  block can accept a request.
- op_sel  in  SEL_W  functional-unit index.
- in_data  in  NUM_IN*WIDTH  unit results; unit k occupies bits [k*WIDTH +: WIDTH].
- in_done  in  NUM_IN  per-unit single-cycle result-valid strobes.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  captured result.
- out_sel  out  SEL_W  select that produced out_data.
- out_zero  out  1  out_data == 0.
- out_err  out  1  result is invalid: timeout or illegal select.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high.
- Reset values: state IDLE, op_ready 1, out_valid 0, out_data 0, out_sel 0, out_zero 0, out_err 0, busy 0, wait counter 0. Reset mid-operation abandons the operation immediately; any in_done arriving afterwards is ignored.
- FSM states: IDLE, WAIT, HOLD. op_ready = (state == IDLE). All outputs are registered.
- IDLE:
  - On op_valid & op_ready, latch op_sel into sel_q and clear the counter.
  - If op_sel >= NUM_IN, go to HOLD with out_data 0, out_err 1, out_zero 0.
  - Otherwise go to WAIT.
  - in_done in the accept cycle is ignored.
- WAIT:
  - Each cycle, sample in_done[sel_q].
  - If it is 1: capture the in_data slice of sel_q into out_data; set out_sel = sel_q, out_zero = (slice == 0), out_err 0; go to HOLD.
  - Else increment the counter. When the counter reaches TIMEOUT, go to HOLD with out_data 0, out_zero 0, out_err 1.
  - in_done on non-selected channels is ignored.
  - Done and the timeout condition in the same cycle: done wins.
- Latency: done sampled in WAIT cycle N gives out_valid = 1 in cycle N+1. With a unit that asserts done the cycle after accept, accept-to-out_valid is 2 cycles.
- HOLD:
  - out_valid 1; out_data, out_sel, out_zero and out_err are stable while out_valid & !out_ready.
  - On out_ready, go to IDLE, out_valid drops next cycle, and the data registers keep their last value.
  - No request is accepted in HOLD; the earliest next accept is the cycle after returning to IDLE.
  - out_ready while not in HOLD has no effect.
- Width rules: no arithmetic on data. The counter is wide enough to hold TIMEOUT and never wraps.

Test Plan:
- Basic capture: op_sel=4 accepted; in_done[4] one cycle later with in_data slice 4 = 8'h3C and other slices 8'hFF -> out_valid two cycles after accept, out_data 8'h3C, out_sel 4, out_zero 0, out_err 0.
- Multi-cycle with backpressure and zero flag: op_sel=7, in_done[7] 10 cycles after accept with data 8'h00, out_ready held low for 3 cycles -> out_data 8'h00, out_zero 1, outputs stable through stall, IDLE one cycle after out_ready.
- Wrong-channel done and timeout: op_sel=6 with only in_done[5] pulsed -> after TIMEOUT=15 WAIT cycles out_valid 1, out_err 1, out_data 0.
- Illegal select: NUM_IN=6, op_sel=7 -> next cycle HOLD, out_err 1, out_sel 7, no WAIT visited.
- Simultaneous events: in_done[sel] asserted on the 15th WAIT cycle -> valid capture with out_err 0. Also, in_done in the accept cycle alone -> ignored, ends in timeout.
- Async reset: rst pulsed mid-clock during WAIT, then in_done[sel] pulsed -> immediate IDLE with all outputs at reset values, and the late done produces no out_valid.

Source files
------------

// File: rtl/alu_result_sel_if.sv
// Handshake and data bundle between the ALU functional units,
// the request source and the result consumer of alu_result_sel.
interface alu_result_sel_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = 3
);
    logic                    op_valid;
    logic                    op_ready;
    logic [SEL_W-1:0]        op_sel;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_done;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_zero;
    logic                    out_err;
    logic                    busy;

    modport master (
        output op_valid, op_sel, in_data, in_done, out_ready,
        input  op_ready, out_valid, out_data, out_sel,
        input  out_zero, out_err, busy
    );

    modport slave (
        input  op_valid, op_sel, in_data, in_done, out_ready,
        output op_ready, out_valid, out_data, out_sel,
        output out_zero, out_err, busy
    );
endinterface

// File: rtl/alu_result_sel.sv
// Registered ALU result selector: accepts a unit select, waits for that
// unit's done strobe (or a timeout), then holds the result until consumed.
module alu_result_sel #(
    parameter int WIDTH   = 8,
    parameter int NUM_IN  = 8,
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = 15
) (
    input logic clk,
    input logic rst,
    alu_result_sel_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] osel_q, osel_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [WIDTH-1:0] data_q, data_d, slice;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic             ready_q, valid_q, busy_q;
    logic             accept, illegal, done_sel, expired;

    assign accept  = bus.op_valid && (state_q == IDLE);
    assign illegal = int'(bus.op_sel) >= NUM_IN;
    assign cnt_inc = cnt_q + CW'(1);
    assign expired = (cnt_inc == CW'(TIMEOUT));

    // Only the latched channel is looked at; other strobes are ignored.
    always_comb begin
        slice    = '0;
        done_sel = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_q == SEL_W'(k)) begin
                slice    = bus.in_data[k*WIDTH +: WIDTH];
                done_sel = bus.in_done[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            osel_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            osel_q  <= osel_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            ready_q <= (state_d == IDLE);
            valid_q <= (state_d == HOLD);
            busy_q  <= (state_d != IDLE);
        end
    end

    // Done has priority over an expiring counter in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = illegal ? HOLD : WAIT;
            WAIT: if (done_sel || expired) state_d = HOLD;
            HOLD: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d  = sel_q;
        osel_d = osel_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        zero_d = zero_q;
        err_d  = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sel_d = bus.op_sel;
                    cnt_d = '0;
                    if (illegal) begin
                        osel_d = bus.op_sel;
                        data_d = '0;
                        zero_d = 1'b0;
                        err_d  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (done_sel) begin
                    osel_d = sel_q;
                    data_d = slice;
                    zero_d = (slice == '0);
                    err_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                    if (expired) begin
                        osel_d = sel_q;
                        data_d = '0;
                        zero_d = 1'b0;
                        err_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.op_ready  = ready_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = osel_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_err   = err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_result_sel.sv
// Bench for alu_result_sel: randomized operations, expected results queued
// from a reference model and checked by an independent output monitor.
module tb_alu_result_sel;
    localparam int W  = 8;
    localparam int N  = 8;
    localparam int N6 = 6;
    localparam int S  = 3;
    localparam int TO = 15;

    typedef struct {
        logic [7:0] data;
        int         sel;
        bit         zero;
        bit         err;
        int         vcyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_result_sel_if #(.WIDTH(W), .NUM_IN(N),  .SEL_W(S)) bus ();
    alu_result_sel_if #(.WIDTH(W), .NUM_IN(N6), .SEL_W(S)) bus6 ();

    alu_result_sel #(.WIDTH(W), .NUM_IN(N), .SEL_W(S), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    alu_result_sel #(.WIDTH(W), .NUM_IN(N6), .SEL_W(S), .TIMEOUT(TO)) dut6 (
        .clk(clk), .rst(rst), .bus(bus6)
    );

    exp_t sbq[$];
    int   checks = 0;
    int   errs = 0;
    int   cyc = 0;
    bit   first_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string n, int got, int want);
        checks++;
        if (got != want) begin
            errs++;
            $display("FAIL %s got %0h want %0h", n, got, want);
        end
    endfunction

    // Reference: legal select with done in WAIT cycle 1..TO yields the data;
    // anything else is an error result with zero data.
    function automatic exp_t model(int sel, int d, logic [7:0] v, int e0, int nin);
        exp_t e;
        e.sel = sel;
        if (sel >= nin) begin
            e.data = 8'h00; e.zero = 0; e.err = 1; e.vcyc = e0;
        end else if (d >= 1 && d <= TO) begin
            e.data = v; e.zero = (v == 8'h00); e.err = 0; e.vcyc = e0 + d;
        end else begin
            e.data = 8'h00; e.zero = 0; e.err = 1; e.vcyc = e0 + TO;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out_valid", int'(bus.out_valid), 0);
            end else begin
                chk("out_data", int'(bus.out_data), int'(sbq[0].data));
                chk("out_sel", int'(bus.out_sel), sbq[0].sel);
                chk("out_zero", int'(bus.out_zero), int'(sbq[0].zero));
                chk("out_err", int'(bus.out_err), int'(sbq[0].err));
                chk("busy_in_hold", int'(bus.busy), 1);
                chk("op_ready_in_hold", int'(bus.op_ready), 0);
                if (!first_seen) begin
                    chk("latency", cyc, sbq[0].vcyc);
                    first_seen = 1;
                end
                if (bus.out_ready) begin
                    void'(sbq.pop_front());
                    first_seen = 0;
                end
            end
        end
    end

    task automatic drive_cycle(int sel, bit fire, logic [7:0] v, bit quiet);
        logic [63:0] dat;
        logic [7:0]  dn;
        if (quiet) begin
            dat = '1;
            dn  = '0;
        end else begin
            dat = {$urandom, $urandom};
            dn  = 8'($urandom);
        end
        dn[sel] = fire;
        if (fire) dat[sel*8 +: 8] = v;
        bus.in_data = dat;
        bus.in_done = dn;
    endtask

    task automatic run_op(int sel, int d, logic [7:0] v, bit acc_done,
                          int stall, bit quiet);
        int e0;
        int c;
        bit seen;
        c = 0;
        while (!bus.op_ready && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        chk("op_ready_before_issue", int'(bus.op_ready), 1);
        bus.op_valid  = 1'b1;
        bus.op_sel    = 3'(sel);
        bus.out_ready = 1'($urandom);
        drive_cycle(sel, acc_done, v, quiet);
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        e0 = cyc;
        sbq.push_back(model(sel, d, v, e0, N));
        seen = bus.out_valid;
        c = 1;
        while (!seen && c <= TO + 3) begin
            drive_cycle(sel, c == d, v, quiet);
            bus.out_ready = 1'($urandom);
            @(posedge clk); #1;
            c++;
            seen = bus.out_valid;
        end
        bus.out_ready = 1'b0;
        bus.in_done   = '0;
        if (!seen) chk("out_valid_arrival", int'(seen), 1);
        repeat (stall) begin
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("op_ready_after_handshake", int'(bus.op_ready), 1);
        chk("out_valid_after_handshake", int'(bus.out_valid), 0);
    endtask

    task automatic check_reset_vals(string tag);
        chk({tag, "_op_ready"}, int'(bus.op_ready), 1);
        chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_out_data"}, int'(bus.out_data), 0);
        chk({tag, "_out_sel"}, int'(bus.out_sel), 0);
        chk({tag, "_out_zero"}, int'(bus.out_zero), 0);
        chk({tag, "_out_err"}, int'(bus.out_err), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    task automatic reset_mid_wait();
        bit late;
        bus.op_valid = 1'b1;
        bus.op_sel   = 3'd3;
        drive_cycle(3, 1'b0, 8'h00, 1'b1);
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("busy_in_wait", int'(bus.busy), 1);
        #1 rst = 1'b1;
        #1 check_reset_vals("async_rst");
        #1 rst = 1'b0;
        late = 0;
        for (int i = 0; i < TO + 4; i++) begin
            drive_cycle(3, i < 2, 8'h55, 1'b1);
            @(posedge clk); #1;
            if (bus.out_valid) late = 1;
        end
        bus.in_done = '0;
        chk("late_done_no_valid", int'(late), 0);
        chk("idle_after_rst", int'(bus.op_ready), 1);
    endtask

    task automatic n6_tests();
        exp_t e;
        int   s;
        int   e0;
        for (int i = 0; i < 3; i++) begin
            s = (i == 0) ? 7 : (i == 1) ? 6 : 5;
            bus6.op_valid = 1'b1;
            bus6.op_sel   = 3'(s);
            bus6.in_data  = '1;
            bus6.in_done  = '0;
            @(posedge clk); #1;
            bus6.op_valid = 1'b0;
            e0 = cyc;
            if (s == 5) begin
                bus6.in_data[5*8 +: 8] = 8'hA5;
                bus6.in_done = 6'b100000;
                @(posedge clk); #1;
                bus6.in_done = '0;
                e = model(s, 1, 8'hA5, e0, N6);
            end else begin
                e = model(s, 0, 8'h00, e0, N6);
            end
            chk("n6_out_valid", int'(bus6.out_valid), 1);
            chk("n6_out_err", int'(bus6.out_err), int'(e.err));
            chk("n6_out_sel", int'(bus6.out_sel), e.sel);
            chk("n6_out_data", int'(bus6.out_data), int'(e.data));
            chk("n6_out_zero", int'(bus6.out_zero), int'(e.zero));
            bus6.out_ready = 1'b1;
            @(posedge clk); #1;
            bus6.out_ready = 1'b0;
            chk("n6_idle", int'(bus6.op_ready), 1);
        end
    endtask

    initial begin
        int sel;
        int d;
        int mode;
        logic [7:0] v;
        bus.op_valid   = 1'b0;
        bus.op_sel     = '0;
        bus.in_data    = '0;
        bus.in_done    = '0;
        bus.out_ready  = 1'b0;
        bus6.op_valid  = 1'b0;
        bus6.op_sel    = '0;
        bus6.in_data   = '0;
        bus6.in_done   = '0;
        bus6.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("reset");
        chk("reset_n6_op_ready", int'(bus6.op_ready), 1);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(4, 1, 8'h3C, 1'b0, 0, 1'b1);
        run_op(7, 10, 8'h00, 1'b0, 3, 1'b1);
        run_op(6, 0, 8'h00, 1'b0, 0, 1'b0);
        run_op(2, TO, 8'h81, 1'b0, 1, 1'b0);
        run_op(1, 0, 8'h77, 1'b1, 0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            sel  = int'($urandom_range(0, N - 1));
            mode = int'($urandom_range(0, 3));
            d    = (mode == 0) ? TO : (mode == 1) ? 0 : int'($urandom_range(1, TO));
            v    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            run_op(sel, d, v, 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        reset_mid_wait();
        n6_tests();

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end
endmodule
